reg_xfer_ctrl: RTL
==================

Name: reg_xfer_ctrl

Overview:
- Sequencer for the three general-purpose registers A, B and C of the 19-bit CPU datapath.
- Accepts one transfer command at a time over a valid/ready handshake: NOP, LOAD immediate, MOVE reg→reg, or SWAP reg↔reg.
- Drives the shared write bus and the per-register load enables.
- Reads current register contents back through the register output ports.
- Sits between the instruction decoder and the A–C register instances.

Parameters:
WORD_SIZE, 19, datapath word width in bits

Ports:
CLK  input  1  system clock, all state changes on rising edge
RST  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command present
CMD_READY  output  1  controller can accept a command
CMD_OP  input  2  00 NOP, 01 LOAD, 10 MOVE, 11 SWAP
CMD_SRC  input  2  source register code: 00 A, 01 B, 10 C, 11 invalid
CMD_DST  input  2  destination register code, same encoding
CMD_IMM  input  WORD_SIZE  immediate data for LOAD
A_Q  input  WORD_SIZE  current output of register A
B_Q  input  WORD_SIZE  current output of register B
C_Q  input  WORD_SIZE  current output of register C
BUS_DATA  output  WORD_SIZE  write data presented to all three registers
LOAD_A  output  1  load enable, register A
LOAD_B  output  1  load enable, register B
LOAD_C  output  1  load enable, register C
DONE  output  1  one-cycle pulse: command completed
ERR  output  1  one-cycle pulse: command rejected

Behaviour:
- Clock is CLK. Reset is RST: asynchronous, active-high.
- On RST assertion, immediately:
  - state = IDLE
  - latched command and TEMP cleared to 0
  - LOAD_A/B/C = 0, BUS_DATA = 0, DONE = 0, ERR = 0, CMD_READY = 0
- CMD_READY = 1 only in IDLE with RST low. It is high in the first cycle after RST deasserts.
- Handshake:
  - Command accepted on a rising edge where CMD_VALID & CMD_READY.
  - OP/SRC/DST/IMM are latched at acceptance.
  - Input changes after acceptance are ignored.
  - CMD_VALID while not ready is held off; the controller never drops it.
- Outputs decode from registered state and the latched command only. There is no combinational path from CMD_* to LOAD_x, BUS_DATA, DONE or ERR.
- Used register fields by OP:
  - LOAD: DST
  - MOVE, SWAP: SRC and DST
  - NOP: none
- Validity check at acceptance: any used field equal to 11 → next state ERROR. Unused fields are ignored.
- States:
  - IDLE: outputs 0.
    - Accept → EXEC (NOP/LOAD/MOVE), SWAP1 (SWAP), or ERROR (invalid).
  - EXEC, one cycle:
    - NOP: no loads.
    - LOAD: BUS_DATA = latched IMM, LOAD_dst = 1.
    - MOVE: BUS_DATA = Q[src], LOAD_dst = 1.
    - DONE = 1.
    - → IDLE.
  - SWAP1, one cycle:
    - BUS_DATA = Q[dst], LOAD_src = 1.
    - TEMP <= Q[src] at the closing edge.
    - → SWAP2.
  - SWAP2, one cycle:
    - BUS_DATA = TEMP, LOAD_dst = 1.
    - DONE = 1.
    - → IDLE.
  - ERROR, one cycle: no loads, BUS_DATA = 0, ERR = 1, DONE = 0. → IDLE.
- At most one LOAD_x is high in any cycle.
- Latency, with acceptance at edge k:
  - NOP/LOAD/MOVE/error: single-cycle operation in cycle k+1. CMD_READY is high again in cycle k+2.
  - SWAP: two cycles, k+1 and k+2. CMD_READY is high again in cycle k+3.
- Throughput: one command per 2 cycles (NOP/LOAD/MOVE/error) or per 3 cycles (SWAP).
- MOVE with src == dst: legal. Reloads the same value, DONE pulses.
- SWAP with src == dst: legal. Two cycles, value unchanged, DONE pulses.
- RST during EXEC/SWAP1/SWAP2/ERROR:
  - The command is abandoned.
  - No DONE or ERR.
  - LOAD_x drops immediately.
  - A register already loaded in SWAP1 keeps its new value. No rollback.
- Data is passed through at WORD_SIZE bits with no arithmetic or truncation.

Test Plan:
- Reset: assert RST mid-cycle → all outputs 0 asynchronously; release → CMD_READY = 1 in the next cycle.
- LOAD: LOAD DST=B, IMM=19'h5A5A5 → next cycle LOAD_B = 1, BUS_DATA = 19'h5A5A5, DONE = 1; B_Q = 19'h5A5A5 afterwards; CMD_READY low one cycle.
- MOVE: A = 19'h00011 and MOVE SRC=A DST=C → LOAD_C = 1, BUS_DATA = 19'h00011, DONE = 1; A unchanged.
- SWAP: A = 19'h7FFFF, C = 19'h00001 and SWAP SRC=A DST=C → cycle 1: LOAD_A, BUS_DATA = 19'h00001; cycle 2: LOAD_C, BUS_DATA = 19'h7FFFF, DONE = 1; final A = 19'h00001, C = 19'h7FFFF.
- Invalid: MOVE SRC=11 DST=A → ERR pulse, no LOAD_x, no DONE. LOAD SRC=11 DST=A executes normally (SRC unused).
- Back-to-back with reset: hold CMD_VALID with LOAD then SWAP queued → SWAP accepted 2 cycles after LOAD; assert RST during SWAP2 → LOAD_C never asserted, no DONE, A holds its SWAP1 value.

Source files
------------

// File: rtl/reg_xfer_ctrl.sv
// rtl/reg_xfer_ctrl.sv - transfer sequencer for general-purpose registers A, B and C
//
// Accepts one NOP / LOAD / MOVE / SWAP command at a time and drives the shared
// write bus plus the per-register load enables.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   CMD_VALID / CMD_READY         command handshake
//   CMD_OP, CMD_SRC, CMD_DST      opcode and register codes (11 = invalid)
//   CMD_IMM                       immediate word for LOAD
//   A_Q, B_Q, C_Q                 current register contents
//   BUS_DATA, LOAD_A/B/C          shared write data and load enables
//   DONE, ERR                     one-cycle completion / rejection pulses
module reg_xfer_ctrl #(
  parameter int WORD_SIZE = 19
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [1:0]           CMD_OP,
  input  logic [1:0]           CMD_SRC,
  input  logic [1:0]           CMD_DST,
  input  logic [WORD_SIZE-1:0] CMD_IMM,
  input  logic [WORD_SIZE-1:0] A_Q,
  input  logic [WORD_SIZE-1:0] B_Q,
  input  logic [WORD_SIZE-1:0] C_Q,
  output logic [WORD_SIZE-1:0] BUS_DATA,
  output logic                 LOAD_A,
  output logic                 LOAD_B,
  output logic                 LOAD_C,
  output logic                 DONE,
  output logic                 ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SWAP1,
    ST_SWAP2,
    ST_ERROR
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;
  localparam logic [1:0] REG_BAD = 2'b11;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [1:0]           src_q, src_d;
  logic [1:0]           dst_q, dst_d;
  logic [WORD_SIZE-1:0] imm_q, imm_d;
  logic [WORD_SIZE-1:0] temp_q, temp_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic                 bad_cmd;
  logic [WORD_SIZE-1:0] q_src, q_dst;
  logic [WORD_SIZE-1:0] bus_data;
  logic [2:0]           load_vec;
  logic                 done_pulse, err_pulse;

  // Register code to one-hot load enable {C, B, A}; the invalid code selects nothing.
  function automatic logic [2:0] reg_sel(input logic [1:0] code);
    case (code)
      2'b00:   reg_sel = 3'b001;
      2'b01:   reg_sel = 3'b010;
      2'b10:   reg_sel = 3'b100;
      default: reg_sel = 3'b000;
    endcase
  endfunction

  assign accept = CMD_VALID & ready_q;

  // Only the fields an opcode actually uses are checked for the invalid code.
  assign bad_cmd = (((CMD_OP == OP_MOVE) || (CMD_OP == OP_SWAP)) && (CMD_SRC == REG_BAD)) ||
                   ((CMD_OP != OP_NOP) && (CMD_DST == REG_BAD));

  // Live register contents selected by the latched source / destination codes.
  always_comb begin
    q_src = '0;
    q_dst = '0;
    case (src_q)
      2'b00:   q_src = A_Q;
      2'b01:   q_src = B_Q;
      2'b10:   q_src = C_Q;
      default: q_src = '0;
    endcase
    case (dst_q)
      2'b00:   q_dst = A_Q;
      2'b01:   q_dst = B_Q;
      2'b10:   q_dst = C_Q;
      default: q_dst = '0;
    endcase
  end

  // Next-state and command latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    temp_d  = temp_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = CMD_OP;
          src_d = CMD_SRC;
          dst_d = CMD_DST;
          imm_d = CMD_IMM;
          if (bad_cmd) begin
            state_d = ST_ERROR;
          end else if (CMD_OP == OP_SWAP) begin
            state_d = ST_SWAP1;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SWAP1: begin
        // Source is captured before its own load lands at this closing edge.
        temp_d  = q_src;
        state_d = ST_SWAP2;
      end
      ST_EXEC, ST_SWAP2, ST_ERROR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode depends only on registered state and the latched command,
  // so the reset forces every output low without waiting for a clock.
  always_comb begin
    bus_data   = '0;
    load_vec   = 3'b000;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    case (state_q)
      ST_EXEC: begin
        done_pulse = 1'b1;
        if (op_q == OP_LOAD) begin
          bus_data = imm_q;
          load_vec = reg_sel(dst_q);
        end else if (op_q == OP_MOVE) begin
          bus_data = q_src;
          load_vec = reg_sel(dst_q);
        end
      end
      ST_SWAP1: begin
        bus_data = q_dst;
        load_vec = reg_sel(src_q);
      end
      ST_SWAP2: begin
        bus_data   = temp_q;
        load_vec   = reg_sel(dst_q);
        done_pulse = 1'b1;
      end
      ST_ERROR: begin
        err_pulse = 1'b1;
      end
      default: begin
        bus_data = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      temp_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      temp_q  <= temp_d;
      ready_q <= ready_d;
    end
  end

  assign CMD_READY = ready_q;
  assign BUS_DATA  = bus_data;
  assign LOAD_A    = load_vec[0];
  assign LOAD_B    = load_vec[1];
  assign LOAD_C    = load_vec[2];
  assign DONE      = done_pulse;
  assign ERR       = err_pulse;

endmodule
